// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 message padder.
package md5_pkg;

  typedef enum logic [1:0] {
    FILL,
    PAD80,
    LEN,
    EMIT
  } pad_state_t;

  localparam int BLOCK_WORDS = 16;
  localparam int LEN_LO_IDX  = 14;
  localparam int LEN_HI_IDX  = 15;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef logic [31:0] blk_word_t;

endpackage

// File: rtl/md5_tail_mask.sv
// Final-word shaping: keeps the first n message bytes and drops the 0x80 pad byte right after them.
// When the word is full (n=4) the pad byte has to go into the following word, flagged by pad_pending.
module md5_tail_mask
  import md5_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  n,
  output logic [31:0] masked,
  output logic        pad_pending
);

  always_comb begin
    masked      = '0;
    pad_pending = (n >= 3'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < int'(n)) begin
        masked[8*k +: 8] = word[8*k +: 8];
      end else if (k == int'(n)) begin
        masked[8*k +: 8] = PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/md5_msg_pad.sv
// Packs a byte message stream into MD5-padded 512-bit blocks (0x80, zero fill, 64-bit LE bit length).
// Define MD5_PAD_BYTE_SWAP_EN to accept big-endian data_i words (byte 0 in [31:24]).
module md5_msg_pad
  import md5_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  data_i,
  input  logic         valid_i,
  input  logic         last_i,
  input  logic [2:0]   bytes_i,
  output logic         ready_o,
  output logic [511:0] block_o,
  output logic         blk_valid_o,
  input  logic         blk_ready_i,
  output logic         blk_last_o,
  output logic         busy_o
);

  pad_state_t       state_q, state_d;
  blk_word_t        blk_q [BLOCK_WORDS];
  blk_word_t        blk_d [BLOCK_WORDS];
  logic [4:0]       idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             pad_tail_q, pad_tail_d;
  logic             len_tail_q, len_tail_d;
  logic             final_q, final_d;
  logic             busy_q, busy_d;
  logic [31:0]      word_in;
  logic [31:0]      masked;
  logic             pad_pending;
  logic [2:0]       n_eff;
  logic [63:0]      len64;

`ifdef MD5_PAD_BYTE_SWAP_EN
  assign word_in = {data_i[7:0], data_i[15:8], data_i[23:16], data_i[31:24]};
`else
  assign word_in = data_i;
`endif

  // Non-final words behave exactly like a full final word, so one write path covers both.
  assign n_eff = (!last_i || bytes_i > 3'd4) ? 3'd4 : bytes_i;

  md5_tail_mask u_tail_mask (
    .word        (word_in),
    .n           (n_eff),
    .masked      (masked),
    .pad_pending (pad_pending)
  );

  always_comb begin
    len64 = '0;
    len64[LEN_W-1:0] = len_q;
  end

  // pad_tail/len_tail remember padding work that spills into the block after the current one.
  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    idx_d      = idx_q;
    len_d      = len_q;
    pad_tail_d = pad_tail_q;
    len_tail_d = len_tail_q;
    final_d    = final_q;
    busy_d     = busy_q;
    unique case (state_q)
      FILL: begin
        if (valid_i) begin
          busy_d              = 1'b1;
          blk_d[idx_q[3:0]]   = masked;
          len_d               = len_q + LEN_W'({n_eff, 3'b000});
          if (!last_i) begin
            idx_d = idx_q + 5'd1;
            if (idx_q == 5'(BLOCK_WORDS - 1)) begin
              state_d = EMIT;
              final_d = 1'b0;
            end
          end else if (!pad_pending) begin
            if (idx_q < 5'(LEN_LO_IDX)) begin
              state_d = LEN;
            end else begin
              state_d    = EMIT;
              len_tail_d = 1'b1;
            end
          end else if (idx_q == 5'(BLOCK_WORDS - 1)) begin
            state_d    = EMIT;
            pad_tail_d = 1'b1;
            len_tail_d = 1'b1;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = PAD80;
          end
        end
      end
      PAD80: begin
        blk_d[idx_q[3:0]] = {24'd0, PAD_BYTE};
        if (idx_q < 5'(LEN_LO_IDX)) begin
          state_d    = LEN;
          len_tail_d = 1'b0;
        end else begin
          state_d    = EMIT;
          len_tail_d = 1'b1;
        end
      end
      LEN: begin
        blk_d[LEN_LO_IDX] = len64[31:0];
        blk_d[LEN_HI_IDX] = len64[63:32];
        len_tail_d        = 1'b0;
        final_d           = 1'b1;
        state_d           = EMIT;
      end
      EMIT: begin
        if (blk_ready_i) begin
          for (int m = 0; m < BLOCK_WORDS; m++) begin
            blk_d[m] = '0;
          end
          idx_d = '0;
          if (final_q) begin
            len_d   = '0;
            busy_d  = 1'b0;
            final_d = 1'b0;
            state_d = FILL;
          end else if (pad_tail_q) begin
            pad_tail_d = 1'b0;
            state_d    = PAD80;
          end else if (len_tail_q) begin
            len_tail_d = 1'b0;
            state_d    = LEN;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FILL;
      for (int m = 0; m < BLOCK_WORDS; m++) begin
        blk_q[m] <= '0;
      end
      idx_q      <= '0;
      len_q      <= '0;
      pad_tail_q <= 1'b0;
      len_tail_q <= 1'b0;
      final_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      pad_tail_q <= pad_tail_d;
      len_tail_q <= len_tail_d;
      final_q    <= final_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    block_o = '0;
    for (int m = 0; m < BLOCK_WORDS; m++) begin
      block_o[m*32 +: 32] = blk_q[m];
    end
  end

  assign ready_o     = (state_q == FILL) && !rst_i;
  assign blk_valid_o = (state_q == EMIT);
  assign blk_last_o  = final_q;
  assign busy_o      = busy_q;

endmodule
